// File: rtl/onehot_dec_pkg.sv
// Shared types and constants for the one-hot decoder.
// State encoding, mode values and the pulse counter width.
package onehot_dec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_PULSE = 2'd2,
        ST_SCAN  = 2'd3
    } state_t;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_PULSE = 1'b1;

    localparam int CNT_W = 8;

endpackage

// File: rtl/onehot_dec_core.sv
// Combinational binary to one-hot decode.
// Every select value maps to exactly one set bit.
module onehot_dec_core #(
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]      sel,
    output logic [(1<<SEL_W)-1:0] dec
);

    // Set only the bit addressed by sel.
    always_comb begin
        dec      = '0;
        dec[sel] = 1'b1;
    end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered, handshaked one-hot decoder with level and pulse modes.
// Optional walking scan enabled by macro ONEHOT_DEC_SCAN_EN.
module onehot_decoder_seq
    import onehot_dec_pkg::*;
#(
    parameter int SEL_W     = 3,
    parameter int PULSE_LEN = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  mode,
`ifdef ONEHOT_DEC_SCAN_EN
    input  logic                  scan_req,
    output logic                  scan_done,
`endif
    output logic [(1<<SEL_W)-1:0] out,
    output logic                  out_valid,
    output logic                  busy
);

    localparam int OUT_W = 1 << SEL_W;
    localparam logic [CNT_W-1:0] PL_M1 = CNT_W'(PULSE_LEN - 1);

    state_t           state;
    state_t           state_d;
    logic [OUT_W-1:0] out_d;
    logic             out_valid_d;
    logic             busy_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic [SEL_W-1:0] dec_sel;
    logic [OUT_W-1:0] dec;
    logic             accept;

`ifdef ONEHOT_DEC_SCAN_EN
    logic [SEL_W-1:0] sidx;
    logic [SEL_W-1:0] sidx_d;
    logic             scan_done_d;
`endif

    assign in_ready = en && (state != ST_PULSE) && (state != ST_SCAN);
    assign accept   = in_valid && in_ready;

    // Single decoder shared by accepts and the scan walker.
    always_comb begin
        dec_sel = in_sel;
`ifdef ONEHOT_DEC_SCAN_EN
        if (state == ST_SCAN) begin
            dec_sel = sidx + SEL_W'(1);
        end else if (!accept) begin
            dec_sel = '0;
        end
`endif
    end

    onehot_dec_core #(
        .SEL_W (SEL_W)
    ) u_core (
        .sel (dec_sel),
        .dec (dec)
    );

    // Next-state and next-output logic; en low wins over accept.
    always_comb begin
        state_d     = state;
        out_d       = out;
        out_valid_d = out_valid;
        busy_d      = busy;
        cnt_d       = cnt;
`ifdef ONEHOT_DEC_SCAN_EN
        sidx_d      = sidx;
        scan_done_d = 1'b0;
`endif
        if (!en) begin
            state_d     = ST_IDLE;
            out_d       = '0;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            cnt_d       = '0;
`ifdef ONEHOT_DEC_SCAN_EN
            sidx_d      = '0;
`endif
        end else begin
            unique case (state)
                ST_IDLE, ST_HOLD: begin
                    if (accept) begin
                        out_d       = dec;
                        out_valid_d = 1'b1;
                        if (mode == MODE_PULSE) begin
                            busy_d  = 1'b1;
                            cnt_d   = PL_M1;
                            state_d = ST_PULSE;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = ST_HOLD;
                        end
                    end
`ifdef ONEHOT_DEC_SCAN_EN
                    else if (scan_req) begin
                        out_d       = dec;
                        out_valid_d = 1'b0;
                        busy_d      = 1'b1;
                        sidx_d      = '0;
                        state_d     = ST_SCAN;
                    end
`endif
                end
                ST_PULSE: begin
                    if (cnt == '0) begin
                        out_d       = '0;
                        out_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        cnt_d = cnt - 1'b1;
                    end
                end
`ifdef ONEHOT_DEC_SCAN_EN
                ST_SCAN: begin
                    if (&sidx) begin
                        out_d       = '0;
                        busy_d      = 1'b0;
                        sidx_d      = '0;
                        scan_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        out_d  = dec;
                        sidx_d = sidx + SEL_W'(1);
                    end
                end
`endif
                default: begin
                    state_d     = ST_IDLE;
                    out_d       = '0;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    cnt_d       = '0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            cnt       <= '0;
`ifdef ONEHOT_DEC_SCAN_EN
            sidx      <= '0;
            scan_done <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            out       <= out_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
            cnt       <= cnt_d;
`ifdef ONEHOT_DEC_SCAN_EN
            sidx      <= sidx_d;
            scan_done <= scan_done_d;
`endif
        end
    end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Self-checking bench for onehot_decoder_seq.
// Table vectors, random run against a model, PULSE_LEN=1 corner.
module tb_onehot_decoder_seq;

    localparam int PL = 4;

    logic       clk = 1'b0;
    logic       rst_n, en, in_valid, mode;
    logic [2:0] in_sel;
    logic       in_ready, out_valid, busy;
    logic [7:0] out;

    logic        d2_rst_n, d2_en, d2_valid, d2_mode;
    logic [3:0]  d2_sel;
    logic        d2_ready, d2_ovalid, d2_busy;
    logic [15:0] d2_out;

`ifdef ONEHOT_DEC_SCAN_EN
    logic scan_req, scan_done;
    logic d2_sreq, d2_sdone;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    onehot_decoder_seq #(.SEL_W(3), .PULSE_LEN(PL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .mode      (mode),
`ifdef ONEHOT_DEC_SCAN_EN
        .scan_req  (scan_req),
        .scan_done (scan_done),
`endif
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy)
    );

    onehot_decoder_seq #(.SEL_W(4), .PULSE_LEN(1)) dut2 (
        .clk       (clk),
        .rst_n     (d2_rst_n),
        .en        (d2_en),
        .in_valid  (d2_valid),
        .in_ready  (d2_ready),
        .in_sel    (d2_sel),
        .mode      (d2_mode),
`ifdef ONEHOT_DEC_SCAN_EN
        .scan_req  (d2_sreq),
        .scan_done (d2_sdone),
`endif
        .out       (d2_out),
        .out_valid (d2_ovalid),
        .busy      (d2_busy)
    );

    typedef struct {
        logic       rn, e, v;
        logic [2:0] s;
        logic       m;
        logic [7:0] xo;
        logic       xv, xb, xr;
    } vec_t;

    vec_t tbl[16];

    // Model: code currently shown (-1 none), high cycles still owed.
    int m_code = -1;
    int m_left = 0;

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %h want %h",
                     nm, idx, act, exp);
        end
    endtask

    task automatic model_step(input logic rn, input logic e,
                              input logic v, input int s,
                              input logic m);
        if (!rn || !e) begin
            m_code = -1;
            m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_code = -1;
        end else if (v) begin
            m_code = s;
            m_left = m ? PL : 0;
        end
    endtask

    task automatic drive(input logic rn, input logic e,
                         input logic v, input logic [2:0] s,
                         input logic m);
        rst_n    = rn;
        en       = e;
        in_valid = v;
        in_sel   = s;
        mode     = m;
        @(posedge clk);
        model_step(rn, e, v, int'(s), m);
        #1;
    endtask

    function automatic vec_t mk(
        logic rn, logic e, logic v, logic [2:0] s, logic m,
        logic [7:0] xo, logic xv, logic xb, logic xr);
        vec_t r;
        r.rn = rn; r.e = e; r.v = v; r.s = s; r.m = m;
        r.xo = xo; r.xv = xv; r.xb = xb; r.xr = xr;
        return r;
    endfunction

    initial begin
        logic [7:0] m_out;
        rst_n = 0; en = 0; in_valid = 0; in_sel = 0; mode = 0;
        d2_rst_n = 0; d2_en = 0; d2_valid = 0;
        d2_sel = 0; d2_mode = 0;
`ifdef ONEHOT_DEC_SCAN_EN
        scan_req = 0;
        d2_sreq  = 0;
`endif

        tbl[0]  = mk(0, 1, 0, 0, 0, 8'h00, 0, 0, 1);
        tbl[1]  = mk(1, 1, 1, 5, 0, 8'h20, 1, 0, 1);
        tbl[2]  = mk(1, 1, 0, 0, 0, 8'h20, 1, 0, 1);
        tbl[3]  = mk(1, 1, 1, 2, 0, 8'h04, 1, 0, 1);
        tbl[4]  = mk(1, 1, 1, 7, 1, 8'h80, 1, 1, 0);
        tbl[5]  = mk(1, 1, 1, 3, 0, 8'h80, 1, 1, 0);
        tbl[6]  = mk(1, 1, 1, 1, 1, 8'h80, 1, 1, 0);
        tbl[7]  = mk(1, 1, 1, 1, 1, 8'h80, 1, 1, 0);
        tbl[8]  = mk(1, 1, 1, 1, 1, 8'h00, 0, 0, 1);
        tbl[9]  = mk(1, 1, 1, 1, 1, 8'h02, 1, 1, 0);
        tbl[10] = mk(1, 1, 0, 0, 0, 8'h02, 1, 1, 0);
        tbl[11] = mk(1, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        tbl[12] = mk(1, 1, 1, 0, 0, 8'h01, 1, 0, 1);
        tbl[13] = mk(1, 1, 1, 4, 0, 8'h10, 1, 0, 1);
        tbl[14] = mk(0, 1, 0, 0, 0, 8'h00, 0, 0, 1);
        tbl[15] = mk(1, 1, 0, 3, 1, 8'h00, 0, 0, 1);

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].rn, tbl[i].e, tbl[i].v,
                  tbl[i].s, tbl[i].m);
            chk("tbl_out",   i, 32'(out),       32'(tbl[i].xo));
            chk("tbl_valid", i, 32'(out_valid), 32'(tbl[i].xv));
            chk("tbl_busy",  i, 32'(busy),      32'(tbl[i].xb));
            chk("tbl_ready", i, 32'(in_ready),  32'(tbl[i].xr));
        end

        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 40) != 0, ($urandom % 15) != 0,
                  1'($urandom), 3'($urandom), 1'($urandom));
            m_out = (m_code < 0) ? 8'h00 : 8'(1 << m_code);
            chk("rnd_out",   i, 32'(out),       32'(m_out));
            chk("rnd_valid", i, 32'(out_valid), 32'(m_code >= 0));
            chk("rnd_busy",  i, 32'(busy),      32'(m_left > 0));
            chk("rnd_ready", i, 32'(in_ready),
                32'(en && m_left == 0));
        end

        d2_rst_n = 0;
        d2_en    = 1;
        @(posedge clk); #1;
        chk("w16_rst", 0, 32'(d2_out), 32'h0);
        d2_rst_n = 1;
        d2_valid = 1;
        d2_sel   = 4'd15;
        d2_mode  = 1;
        @(posedge clk); #1;
        chk("w16_out",  1, 32'(d2_out),  32'h8000);
        chk("w16_busy", 1, 32'(d2_busy), 32'h1);
        chk("w16_rdy",  1, 32'(d2_ready), 32'h0);
        d2_valid = 0;
        @(posedge clk); #1;
        chk("w16_out",  2, 32'(d2_out),  32'h0);
        chk("w16_busy", 2, 32'(d2_busy), 32'h0);
        chk("w16_rdy",  2, 32'(d2_ready), 32'h1);

`ifdef ONEHOT_DEC_SCAN_EN
        drive(0, 1, 0, 0, 0);
        scan_req = 1;
        drive(1, 1, 0, 0, 0);
        scan_req = 0;
        chk("scan_out", 0, 32'(out), 32'h01);
        for (int i = 1; i < 8; i++) begin
            @(posedge clk); #1;
            chk("scan_out",  i, 32'(out),       32'(1 << i));
            chk("scan_busy", i, 32'(busy),      32'h1);
            chk("scan_done", i, 32'(scan_done), 32'h0);
        end
        @(posedge clk); #1;
        chk("scan_end",  8, 32'(out),       32'h0);
        chk("scan_done", 8, 32'(scan_done), 32'h1);
        @(posedge clk); #1;
        chk("scan_done", 9, 32'(scan_done), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
